// File: rtl/filter_state_sequencer_pkg.sv
// Shared types for the filter state sequencer: per-channel filter state word and
// sequencer FSM states.
package filter_state_sequencer_pkg;

  typedef struct packed {
    logic [31:0] z1;
    logic [31:0] z2;
  } digital_filter_data_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush,
    StClear
  } seq_state_e;

endpackage

// File: rtl/filter_state_ram.sv
// Per-channel filter state storage: asynchronous read, synchronous write,
// asynchronous reset to zero.
module filter_state_ram
  import filter_state_sequencer_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 16,
  parameter int unsigned CH_W         = $clog2(NUM_CHANNELS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 we,
  input  logic [CH_W-1:0]      waddr,
  input  digital_filter_data_t wdata,
  input  logic [CH_W-1:0]      raddr,
  output digital_filter_data_t rdata
);

  digital_filter_data_t mem_q [NUM_CHANNELS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/filter_state_sequencer.sv
// Sweeps every channel through the shared filter twice per sample period and
// writes each channel's result back into the state RAM.
module filter_state_sequencer
  import filter_state_sequencer_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 16,
  parameter int unsigned CH_W         = $clog2(NUM_CHANNELS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sample_strobe,
  input  logic                 clear_req,
  input  logic                 overrun_clear,
  output logic [CH_W-1:0]      channel,
  output logic                 pass,
  output digital_filter_data_t filter_data,
  input  digital_filter_data_t filter_odata,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  localparam logic [CH_W-1:0] LastCh = CH_W'(NUM_CHANNELS - 1);

  seq_state_e           state_q, state_d;
  logic [CH_W-1:0]      cnt_q, cnt_d;
  logic                 pass_q, pass_d;
  logic                 overrun_q, overrun_d;
  logic                 we;
  logic [CH_W-1:0]      waddr;
  digital_filter_data_t wdata;
  digital_filter_data_t rdata;

  filter_state_ram #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .CH_W         (CH_W)
  ) u_ram (
    .clock (clock),
    .reset (reset),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (cnt_q),
    .rdata (rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pass_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pass_q    <= pass_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    we      = 1'b0;
    waddr   = cnt_q;
    wdata   = filter_odata;
    unique case (state_q)
      StIdle: begin
        if (clear_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end else if (sample_strobe) begin
          state_d = StRun;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end
      end
      StRun: begin
        if (!pass_q) begin
          pass_d = 1'b1;
          // Previous channel's pass-1 result is now on filter_odata.
          if (cnt_q != '0) begin
            we    = 1'b1;
            waddr = cnt_q - CH_W'(1);
          end
        end else begin
          pass_d = 1'b0;
          if (cnt_q == LastCh) begin
            state_d = StFlush;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CH_W'(1);
          end
        end
      end
      StFlush: begin
        we      = 1'b1;
        waddr   = LastCh;
        state_d = StIdle;
      end
      StClear: begin
        we    = 1'b1;
        wdata = '0;
        if (cnt_q == LastCh) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CH_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Set wins over clear; clear_req beats a coincident strobe in IDLE.
  always_comb begin
    overrun_d = overrun_q;
    if (sample_strobe && (state_q != StIdle || clear_req)) begin
      overrun_d = 1'b1;
    end else if (overrun_clear) begin
      overrun_d = 1'b0;
    end
  end

  always_comb begin
    busy        = (state_q != StIdle);
    done        = (state_q == StFlush);
    overrun     = overrun_q;
    channel     = '0;
    pass        = 1'b0;
    filter_data = '0;
    if (state_q == StRun) begin
      channel     = cnt_q;
      pass        = pass_q;
      filter_data = pass_q ? filter_odata : rdata;
    end
  end

endmodule

// File: doc/filter_state_sequencer.md
FILTER_STATE_SEQUENCER -- requirements
Module: filter_state_sequencer

Interface
REQ-001 Parameter NUM_CHANNELS, default 16, number of filter channels served per sample period (power of two, 2..64).
REQ-002 Parameter CH_W, default $clog2(NUM_CHANNELS), channel index width.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sample_strobe  input  1  one-cycle pulse starting a sweep over all channels.
REQ-006 clear_req  input  1  one-cycle pulse requesting all channel state be zeroed.
REQ-007 overrun_clear  input  1  clears the sticky overrun flag.
REQ-008 channel  output  CH_W  index of the channel currently presented to the filter.
REQ-009 pass  output  1  0 = first pass, 1 = second pass of the current channel.
REQ-010 filter_data  output  64  DigitalFilterData {z1,z2} driven to the filter DATA input.
REQ-011 filter_odata  input  64  DigitalFilterData returned from the filter oDATA register.
REQ-012 busy  output  1  high while a sweep or clear is in progress.
REQ-013 done  output  1  one-cycle pulse when a sweep completes.
REQ-014 overrun  output  1  sticky; a strobe arrived while busy.

Function
REQ-015 States: IDLE, RUN, FLUSH, CLEAR; reset state IDLE.
REQ-016 IDLE + sample_strobe: next cycle RUN with channel=0, pass=0.
REQ-017 RUN alternates pass 0/1 each cycle; channel increments after pass=1; channel N-1 pass=1 is followed by FLUSH.
REQ-018 pass=0 cycle: filter_data = state RAM[channel] (combinational read).
REQ-019 pass=1 cycle: filter_data = filter_odata (bypass of pass-0 result).
REQ-020 The pass=0 cycle of channel c+1 writes filter_odata into RAM[c]; the FLUSH cycle writes filter_odata into RAM[N-1].
REQ-021 FLUSH lasts one cycle, asserts done, then returns to IDLE.
REQ-022 Timing: strobe in cycle 0 gives busy high in cycles 1..2N+1 and done in cycle 2N+1; N=16 gives 33 busy cycles.
REQ-023 sample_strobe while busy (any non-IDLE state) is ignored and sets overrun; the sweep is not restarted.
REQ-024 overrun clears on overrun_clear; if the strobe and clear coincide, set wins.
REQ-025 IDLE + clear_req: CLEAR for N cycles, writing zero to RAM[0..N-1] in order, then IDLE; no done pulse.
REQ-026 clear_req while not IDLE is ignored.
REQ-027 sample_strobe and clear_req together in IDLE: clear wins and the strobe sets overrun.
REQ-028 In IDLE and CLEAR, channel=0, pass=0, filter_data=0.
REQ-029 The channel counter wraps only through FLUSH; it never exceeds N-1.
REQ-030 filter_data, filter_odata and RAM entries are stored unmodified as 64-bit values; no arithmetic or saturation is applied.

Reset
REQ-031 reset clears all outputs, all RAM entries, overrun, the counter and the pass bit, and forces IDLE, all asynchronously.
REQ-032 reset asserted mid-RUN abandons the sweep without any writeback; no done pulse.

Structure
REQ-033 The DigitalFilterData typedef and the state enum (IDLE/RUN/FLUSH/CLEAR) live in the shared synthesizer package.
REQ-034 Storage is one sub-module, filter_state_ram: NUM_CHANNELS x 64, one asynchronous read port, one synchronous write port, async reset to zero.

Verification
REQ-035 Reset, then strobe; loopback model odata = data + {32'd1,32'd1} -> after done, every RAM[c] = {2,2}; done in cycle 33.
REQ-036 Preload RAM[5] = {A,B} via prior sweeps, strobe -> in the channel 5 pass=0 cycle filter_data equals RAM[5]; in the pass=1 cycle it equals filter_odata.
REQ-037 Strobe again at cycle 10 of a sweep -> overrun=1; sweep still ends at cycle 33; overrun_clear -> overrun=0.
REQ-038 clear_req in IDLE -> busy for 16 cycles; next sweep presents {0,0} on every pass=0 cycle.
REQ-039 reset pulse at cycle 15 of a sweep -> state IDLE immediately, all outputs 0, no done pulse, RAM all zero.
REQ-040 Strobe and clear_req in the same IDLE cycle -> CLEAR is entered, overrun=1, no done pulse.
